// File: rtl/imem_loader.sv
// Instruction memory loader: packs a valid/ready byte stream little-endian into 32-bit
// words and writes them at consecutive word-aligned addresses while holding the core.
module imem_loader #(
    parameter int DEPTH = 64,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      base_addr,
    input  logic [LEN_W-1:0] word_count,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             imem_we,
    output logic [31:0]      imem_addr,
    output logic [31:0]      imem_wdata,
    output logic             core_hold,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [31:0]      checksum
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RECV  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [31:0]      addr;
    logic [LEN_W-1:0] remaining;
    logic [1:0]       byte_idx;
    logic [31:0]      word_asm;

    logic             idle_like;
    logic             start_ok;
    logic             abort_ok;
    logic             byte_acc;
    logic             last_byte;
    logic             write_go;
    logic             last_word;
    logic             range_bad;
    logic [32:0]      end_word;

    // Range check in word units with one spare bit so the sum cannot wrap.
    assign end_word  = {3'b000, base_addr[31:2]} + {{(33-LEN_W){1'b0}}, word_count};
    assign range_bad = (end_word > 33'(DEPTH));

    assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
    assign start_ok  = idle_like && start;
    assign abort_ok  = abort && ((state == S_RECV) || (state == S_WRITE));
    assign byte_acc  = (state == S_RECV) && byte_valid;
    assign last_byte = (byte_idx == 2'd3);
    assign write_go  = (state == S_WRITE) && !abort;
    assign last_word = (remaining == LEN_W'(1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    if (word_count == '0)
                        state_nxt = S_DONE;
                    else if (range_bad)
                        state_nxt = S_ERROR;
                    else
                        state_nxt = S_RECV;
                end
            end
            S_RECV: begin
                if (abort)
                    state_nxt = S_IDLE;
                else if (byte_acc && last_byte)
                    state_nxt = S_WRITE;
            end
            S_WRITE: begin
                // Abort beats the write: the strobe is already masked combinationally.
                if (abort)
                    state_nxt = S_IDLE;
                else if (last_word)
                    state_nxt = S_DONE;
                else
                    state_nxt = S_RECV;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr       <= '0;
            remaining  <= '0;
            byte_idx   <= '0;
            word_asm   <= '0;
            checksum   <= '0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else if (start_ok) begin
            addr      <= {base_addr[31:2], 2'b00};
            remaining <= word_count;
            byte_idx  <= '0;
            word_asm  <= '0;
            checksum  <= '0;
        end else if (abort_ok) begin
            byte_idx <= '0;
            word_asm <= '0;
        end else if (byte_acc) begin
            word_asm[{byte_idx, 3'b000} +: 8] <= byte_data;
            byte_idx <= byte_idx + 2'd1;
            // Write port registers are loaded once per word so they hold between writes.
            if (last_byte) begin
                imem_addr  <= addr;
                imem_wdata <= {byte_data, word_asm[23:0]};
            end
        end else if (write_go) begin
            checksum  <= checksum ^ imem_wdata;
            addr      <= addr + 32'd4;
            remaining <= remaining - LEN_W'(1);
            byte_idx  <= '0;
            word_asm  <= '0;
        end
    end

    assign byte_ready = (state == S_RECV);
    assign imem_we    = write_go;
    assign busy       = (state == S_RECV) || (state == S_WRITE);
    assign core_hold  = busy;
    assign done       = (state == S_DONE);
    assign error      = (state == S_ERROR);

endmodule
